// File: rtl/danger_pkg.sv
// rtl/danger_pkg.sv - obstacle kind codes, sprite geometry and geometry lookup
package danger_pkg;

    typedef enum logic [2:0] {
        LOW_BIRD     = 3'd0,
        HIGH_BIRD    = 3'd1,
        SMALL_CACTUS = 3'd2,
        MANY_CACTUS  = 3'd3,
        BIG_CACTUS   = 3'd4,
        NOTHING      = 3'd5
    } danger_kind_e;

    localparam logic [6:0] SMALL_W = 7'd19;
    localparam logic [5:0] SMALL_H = 6'd36;
    localparam logic [6:0] BIG_W   = 7'd27;
    localparam logic [5:0] BIG_H   = 6'd50;
    localparam logic [6:0] MANY_W  = 7'd77;
    localparam logic [5:0] MANY_H  = 6'd49;
    localparam logic [6:0] BIRD_W  = 7'd44;
    localparam logic [5:0] BIRD_H  = 6'd33;

    localparam logic [9:0] CACTUS_Y_BASE    = 10'd298;
    localparam logic [9:0] LOW_BIRD_Y_BASE  = 10'd290;
    localparam logic [9:0] HIGH_BIRD_Y_BASE = 10'd250;

    // Second wing frame sits directly after the first in the bird ROM.
    localparam logic [16:0] BIRD_FRAME_WORDS = 17'd1452;

    typedef struct packed {
        logic [6:0] w;
        logic [5:0] h;
        logic [9:0] y_base;
    } danger_geom_t;

    function automatic danger_geom_t kind_geom(input logic [2:0] kind);
        danger_geom_t g;
        case (kind)
            LOW_BIRD:     g = '{w: BIRD_W,  h: BIRD_H,  y_base: LOW_BIRD_Y_BASE};
            HIGH_BIRD:    g = '{w: BIRD_W,  h: BIRD_H,  y_base: HIGH_BIRD_Y_BASE};
            SMALL_CACTUS: g = '{w: SMALL_W, h: SMALL_H, y_base: CACTUS_Y_BASE};
            MANY_CACTUS:  g = '{w: MANY_W,  h: MANY_H,  y_base: CACTUS_Y_BASE};
            BIG_CACTUS:   g = '{w: BIG_W,   h: BIG_H,   y_base: CACTUS_Y_BASE};
            default:      g = '{w: 7'd0,    h: 6'd0,    y_base: 10'd0};
        endcase
        return g;
    endfunction

    function automatic logic kind_drawable(input logic [2:0] kind);
        return kind <= 3'd4;
    endfunction

    function automatic logic kind_is_bird(input logic [2:0] kind);
        return (kind == LOW_BIRD) || (kind == HIGH_BIRD);
    endfunction

endpackage

// File: rtl/danger_channel.sv
// rtl/danger_channel.sv - one obstacle channel: frame shadow, box test, ROM address, hit delay
module danger_channel
    import danger_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        latch,
    input  logic        phase,
    input  logic [9:0]  h_cnt,
    input  logic [9:0]  v_cnt,
    input  logic [9:0]  pos_in,
    input  logic [2:0]  type_in,
    input  logic        en_in,
    output logic [16:0] rom_addr,
    output logic [2:0]  rom_kind,
    output logic        hit_s1
);

    logic [9:0]         pos_q;
    logic [2:0]         type_q;
    logic               en_q;
    danger_geom_t       geom;
    logic signed [11:0] left_x;
    logic signed [11:0] col_off;
    logic [9:0]         top_y;
    logic [9:0]         row_off;
    logic               in_box;
    logic               hit_s0;
    logic [16:0]        addr_next;

    // left_x may go negative: the box slides off the left edge but keeps its offsets.
    always_comb begin
        geom      = kind_geom(type_q);
        left_x    = $signed({2'b00, pos_q}) - $signed({5'b00000, geom.w}) + 12'sd1;
        col_off   = $signed({2'b00, h_cnt}) - left_x;
        top_y     = geom.y_base - {4'b0000, geom.h} + 10'd1;
        row_off   = v_cnt - top_y;
        in_box    = en_q && kind_drawable(type_q)
                    && (col_off >= 12'sd0) && (h_cnt <= pos_q)
                    && (v_cnt >= top_y) && (v_cnt <= geom.y_base);
        addr_next = 17'(row_off) * 17'(geom.w) + 17'(col_off)
                    + ((phase && kind_is_bird(type_q)) ? BIRD_FRAME_WORDS : 17'd0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pos_q    <= 10'd0;
            type_q   <= NOTHING;
            en_q     <= 1'b0;
            rom_addr <= 17'd0;
            hit_s0   <= 1'b0;
            hit_s1   <= 1'b0;
        end else begin
            if (latch) begin
                pos_q  <= pos_in;
                type_q <= type_in;
                en_q   <= en_in;
            end
            if (in_box) begin
                rom_addr <= addr_next;
            end
            hit_s0 <= in_box;
            hit_s1 <= hit_s0;
        end
    end

    assign rom_kind = type_q;

endmodule

// File: rtl/danger_sprite_engine.sv
// rtl/danger_sprite_engine.sv - N-channel obstacle renderer; DANGER_ANIM_EN enables bird wing animation
module danger_sprite_engine
    import danger_pkg::*;
#(
    parameter int               N_CH        = 3,
    parameter int               PIX_W       = 12,
    parameter logic [PIX_W-1:0] BG_COLOR    = 12'hFFF,
    parameter int               LATCH_LINE  = 308,
    parameter int               ANIM_FRAMES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [9:0]        h_cnt,
    input  logic [9:0]        v_cnt,
    input  logic [N_CH*10-1:0] danger_pos,
    input  logic [N_CH*3-1:0]  danger_type,
    input  logic [N_CH-1:0]    danger_en,
    output logic [N_CH*17-1:0] rom_addr,
    output logic [N_CH*3-1:0]  rom_kind,
    input  logic [N_CH*PIX_W-1:0] rom_data,
    output logic [PIX_W-1:0]   pixel,
    output logic               danger_hit
);

    logic            latch;
    logic            anim_phase;
    logic [N_CH-1:0] hit_s1;
    logic [PIX_W-1:0] win_pix;
    logic            win_hit;

    // Sampled once per frame, below the playfield, so a frame never tears.
    assign latch = (v_cnt == 10'(LATCH_LINE)) && (h_cnt == 10'd0);

`ifdef DANGER_ANIM_EN
    localparam int FC_W = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;

    logic [FC_W-1:0] frame_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_cnt  <= '0;
            anim_phase <= 1'b0;
        end else if (latch) begin
            if (frame_cnt == FC_W'(ANIM_FRAMES - 1)) begin
                frame_cnt  <= '0;
                anim_phase <= ~anim_phase;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end
`else
    assign anim_phase = 1'b0;
`endif

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        danger_channel u_ch (
            .clk      (clk),
            .rst      (rst),
            .latch    (latch),
            .phase    (anim_phase),
            .h_cnt    (h_cnt),
            .v_cnt    (v_cnt),
            .pos_in   (danger_pos[10*i +: 10]),
            .type_in  (danger_type[3*i +: 3]),
            .en_in    (danger_en[i]),
            .rom_addr (rom_addr[17*i +: 17]),
            .rom_kind (rom_kind[3*i +: 3]),
            .hit_s1   (hit_s1[i])
        );
    end

    // Walk from the highest index down so the lowest opaque channel overrides.
    always_comb begin
        win_pix = BG_COLOR;
        win_hit = 1'b0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (hit_s1[i] && (rom_data[i*PIX_W +: PIX_W] != BG_COLOR)) begin
                win_pix = rom_data[i*PIX_W +: PIX_W];
                win_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pixel      <= BG_COLOR;
            danger_hit <= 1'b0;
        end else begin
            pixel      <= win_pix;
            danger_hit <= win_hit;
        end
    end

endmodule
